// File: rtl/password_entry_unit_pkg.sv
// Shared definitions for the password entry unit: keypad command codes,
// a digit classifier and the controller state encoding.
package password_entry_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hC;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SUBMIT  = 2'd2,
    HOLD    = 2'd3
  } state_e;

  // True for BCD digit codes 0x0-0x9.
  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

  // True for the three command codes that COLLECT acts on.
  function automatic logic is_command(input logic [3:0] code);
    return (code == KEY_CLEAR) || (code == KEY_BKSP) || (code == KEY_ENTER);
  endfunction

endpackage

// File: rtl/password_entry_unit_if.sv
// Keypad-side and controller-side signals of the password entry unit.
//   entry_en     : controller permits entry
//   key_valid    : one-cycle key strobe
//   key_code     : 4-bit key code
//   psswrd_atmpt : assembled attempt (PSWD_W bits)
//   try_psswrd   : one-cycle attempt-valid pulse
//   digit_cnt    : digits currently held (CNT_W bits)
//   entry_error  : one-cycle error pulse
//   busy         : unit not idle
interface password_entry_unit_if #(
  parameter int unsigned PSWD_W = 8,
  parameter int unsigned CNT_W  = 2
);
  logic              entry_en;
  logic              key_valid;
  logic [3:0]        key_code;
  logic [PSWD_W-1:0] psswrd_atmpt;
  logic              try_psswrd;
  logic [CNT_W-1:0]  digit_cnt;
  logic              entry_error;
  logic              busy;

  // Keypad / controller side
  modport master (
    output entry_en, key_valid, key_code,
    input  psswrd_atmpt, try_psswrd, digit_cnt, entry_error, busy
  );

  // Password entry unit side
  modport slave (
    input  entry_en, key_valid, key_code,
    output psswrd_atmpt, try_psswrd, digit_cnt, entry_error, busy
  );
endinterface

// File: rtl/password_entry_unit_entry_timer.sv
// Up-counter shared by the inter-key timeout and the post-submit hold.
//   clk, rst : clock, async active-high reset
//   clr      : force count to zero (wins over en)
//   en       : increment count
//   limit    : terminal value; tc_c is high while count == limit-1
//   tc_c     : combinational terminal-count flag
module entry_timer #(
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc_c
);

  logic [W-1:0] count_q, count_d;

  // Next count: clear has priority over increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flags the cycle whose increment would reach the limit.
  assign tc_c = (count_q == (limit - W'(1)));

endmodule

// File: rtl/password_entry_unit.sv
// Keypad front-end: assembles BCD digits into a password attempt, handles
// clear/backspace/timeout and presents the attempt with a one-cycle pulse.
//   clk, rst : clock, async active-high reset
//   bus      : slave modport carrying entry_en/key_valid/key_code in and
//              psswrd_atmpt/try_psswrd/digit_cnt/entry_error/busy out
module password_entry_unit
  import password_entry_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 2000,
  parameter int unsigned HOLD_CYCLES    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  password_entry_unit_if.slave bus
);

  localparam int unsigned PSWD_W  = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W   = $clog2(NUM_DIGITS + 1);
  localparam int unsigned TMR_MAX = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);

  // Timeout fires on the cycle the idle count would reach TIMEOUT_CYCLES-1.
  localparam logic [TMR_W-1:0] TO_LIMIT   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LIMIT = TMR_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(NUM_DIGITS);

  state_e            state_q, state_d;
  logic [PSWD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PSWD_W-1:0] atmpt_q, atmpt_d;
  logic              try_q, try_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              tmr_clr;
  logic              tmr_en;
  logic              tmr_tc_c;
  logic [TMR_W-1:0]  tmr_limit;
  logic              key_digit;
  logic              key_cmd;

  assign key_digit = bus.key_valid && is_digit(bus.key_code);
  assign key_cmd   = bus.key_valid && is_command(bus.key_code);
  assign tmr_limit = (state_q == HOLD) ? HOLD_LIMIT : TO_LIMIT;

  entry_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .limit (tmr_limit),
    .tc_c  (tmr_tc_c)
  );

  // Next state, shift register, digit count, timer control and outputs.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;

    unique case (state_q)
      IDLE: begin
        tmr_clr = 1'b1;
        if (bus.entry_en && key_digit) begin
          shreg_d = PSWD_W'(bus.key_code);
          cnt_d   = CNT_W'(1);
          state_d = COLLECT;
        end
      end

      COLLECT: begin
        if (!bus.entry_en) begin
          // Abort silently; beats any key or timeout this cycle.
          shreg_d = '0;
          cnt_d   = '0;
          tmr_clr = 1'b1;
          state_d = IDLE;
        end else if (key_digit || key_cmd) begin
          // Any acted-on key (including a dropped overflow digit) restarts the timer.
          tmr_clr = 1'b1;
          if (key_digit) begin
            if (cnt_q < CNT_FULL) begin
              shreg_d = (shreg_q << 4) | PSWD_W'(bus.key_code);
              cnt_d   = cnt_q + CNT_W'(1);
            end else begin
              err_d = 1'b1;
            end
          end else if (bus.key_code == KEY_CLEAR) begin
            shreg_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end else if (bus.key_code == KEY_BKSP) begin
            shreg_d = shreg_q >> 4;
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d = IDLE;
            end
          end else begin
            if (cnt_q == CNT_FULL) begin
              state_d = SUBMIT;
            end else begin
              err_d   = 1'b1;
              shreg_d = '0;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end
        end else if (tmr_tc_c) begin
          err_d   = 1'b1;
          shreg_d = '0;
          cnt_d   = '0;
          tmr_clr = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end

      SUBMIT: begin
        tmr_clr = 1'b1;
        state_d = HOLD;
      end

      HOLD: begin
        if (tmr_tc_c) begin
          shreg_d = '0;
          cnt_d   = '0;
          tmr_clr = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs follow the next state so they register alongside it.
    try_d   = (state_d == SUBMIT);
    atmpt_d = ((state_d == SUBMIT) || (state_d == HOLD)) ? shreg_d : '0;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      atmpt_q <= '0;
      try_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      atmpt_q <= atmpt_d;
      try_q   <= try_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.psswrd_atmpt = atmpt_q;
  assign bus.try_psswrd   = try_q;
  assign bus.digit_cnt    = cnt_q;
  assign bus.entry_error  = err_q;
  assign bus.busy         = busy_q;

endmodule

// File: doc/password_entry_unit.md
Name: password_entry_unit

Overview:
Keypad front-end that sits directly upstream of the parking access controller. It collects BCD digits from a debounced keypad and assembles them into the 8-bit password attempt. On ENTER it presents the attempt on psswrd_atmpt with a one-cycle try_psswrd pulse. It also handles clear, backspace and inter-key timeout, so the controller never sees a partial entry.

Parameters:
NUM_DIGITS, 2, number of BCD digits per attempt; PSWD_W = 4*NUM_DIGITS (8 at default)
TIMEOUT_CYCLES, 2000, idle cycles allowed between accepted keys before the entry is discarded
HOLD_CYCLES, 16, cycles the submitted value stays on psswrd_atmpt after the pulse; keys are ignored during this time

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
entry_en  input  1  controller permits entry (vehicle waiting); low forces abort
key_valid  input  1  one-cycle strobe, key_code valid
key_code  input  4  0x0-0x9 digit, 0xA CLEAR, 0xB BACKSPACE, 0xC ENTER, 0xD-0xF ignored
psswrd_atmpt  output  PSWD_W  assembled attempt, first digit in MS nibble; 0 outside SUBMIT/HOLD
try_psswrd  output  1  one-cycle pulse, attempt valid
digit_cnt  output  clog2(NUM_DIGITS+1)  digits currently held
entry_error  output  1  one-cycle pulse on overflow, short ENTER or timeout
busy  output  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE. Shift register=0, digit_cnt=0, timer=0. psswrd_atmpt=0, try_psswrd=0, entry_error=0, busy=0.
- States: IDLE, COLLECT, SUBMIT, HOLD. All outputs are registered. A key sampled at edge N has its effect visible after edge N.
- IDLE:
  - Digit with entry_en=1: reg = {0..,digit}, digit_cnt=1, go to COLLECT.
  - Command codes and 0xD-0xF are ignored. All keys are ignored when entry_en=0.
- COLLECT, digit key:
  - If cnt<NUM_DIGITS: reg = {reg[PSWD_W-5:0],digit}, cnt+1.
  - If cnt==NUM_DIGITS: key dropped, entry_error pulse, contents kept.
- COLLECT, BACKSPACE: reg = reg>>4, cnt-1. If cnt reaches 0, go to IDLE with no error.
- COLLECT, CLEAR: reg=0, cnt=0, go to IDLE, no error.
- COLLECT, ENTER:
  - cnt==NUM_DIGITS: go to SUBMIT.
  - Otherwise: entry_error pulse, reg=0, cnt=0, go to IDLE.
- COLLECT timer:
  - The timer resets on every accepted key (including a dropped overflow digit) and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1: entry_error pulse, reg=0, cnt=0, go to IDLE.
- SUBMIT (1 cycle): try_psswrd=1, psswrd_atmpt=reg. Then go to HOLD with timer=0.
- HOLD: psswrd_atmpt=reg, try_psswrd=0, keys ignored. After HOLD_CYCLES: reg=0, cnt=0, go to IDLE.
- entry_en falling in COLLECT: abort to IDLE, clear, no error pulse. In SUBMIT/HOLD, entry_en is ignored and the sequence completes.
- Simultaneous events:
  - entry_en=0 beats a key.
  - An accepted key beats timer expiry in the same cycle (key processed, timer reset).
  - Only one key per strobe.
- Exactly one try_psswrd pulse per ENTER. try_psswrd and entry_error are never high together.
- digit_cnt saturates at NUM_DIGITS and never underflows.

Decomposition:
- Package password_entry_pkg holds:
  - key code constants KEY_CLEAR=4'hA, KEY_BKSP=4'hB, KEY_ENTER=4'hC, and an is_digit helper;
  - the state encoding IDLE/COLLECT/SUBMIT/HOLD.
- One sub-module, entry_timer: parameterised up-counter with clear/enable and a terminal-count output, sized clog2(max(TIMEOUT_CYCLES,HOLD_CYCLES)). It is shared by the COLLECT timeout and the HOLD count.

Test Plan:
- Keys 3, 7, ENTER, entry_en=1 -> try_psswrd pulses 1 cycle with psswrd_atmpt=8'h37. The value holds 16 cycles, then psswrd_atmpt=0 and busy=0.
- Keys 1, 2, 5 (overflow), ENTER -> entry_error pulse on key 5, then try_psswrd with 8'h12.
- Keys 4, BACKSPACE, 9, 6, ENTER -> 8'h96 submitted. Keys 4, ENTER (short) -> entry_error, no try_psswrd, IDLE.
- Key 8, then 2000 idle cycles -> entry_error at cycle 1999, digit_cnt=0. Key at cycle 1999 instead -> no error, digit_cnt=2.
- Key 5 then entry_en=0 -> IDLE, no error. Keys pressed during HOLD -> ignored. rst asserted mid-COLLECT -> all outputs 0 immediately, without waiting for a clock edge.
- Back-to-back: 3, 7, ENTER, then 3, 7, ENTER issued during HOLD -> exactly one try_psswrd pulse. The second sequence is accepted only after returning to IDLE.
